// File: rtl/frame_buffer_if.sv
// Client-facing bus of the frame store: processor, loader, display and control signals.
// The master modport is the client side; the slave modport is the frame_buffer side.
interface frame_buffer_if;
   logic        proc_active;
   logic [14:0] proc_address;
   logic        proc_we;
   logic [23:0] proc_wdata;
   logic [23:0] proc_rdata;
   logic        load_start;
   logic        load_valid;
   logic [23:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic        disp_req;
   logic [14:0] disp_address;
   logic [23:0] disp_data;
   logic        disp_valid;
   logic        clear_start;
   logic        busy;
   logic        addr_error;

   modport master (
      output proc_active, proc_address, proc_we, proc_wdata,
      output load_start, load_valid, load_data, disp_req, disp_address, clear_start,
      input  proc_rdata, load_ready, load_done, disp_data, disp_valid, busy, addr_error
   );

   modport slave (
      input  proc_active, proc_address, proc_we, proc_wdata,
      input  load_start, load_valid, load_data, disp_req, disp_address, clear_start,
      output proc_rdata, load_ready, load_done, disp_data, disp_valid, busy, addr_error
   );
endinterface

// File: rtl/frame_buffer.sv
// Single-port WIDTHxHEIGHT RGB frame store arbitrating processor, loader and display.
// Optional macro FB_RANGE_CHECK_EN adds out-of-range detection (reads 0, drops writes, sticky addr_error).
module frame_buffer #(
   parameter int          WIDTH       = 160,
   parameter int          HEIGHT      = 120,
   parameter int          DEPTH       = WIDTH * HEIGHT,
   parameter logic [23:0] CLEAR_VALUE = 24'h000000
) (
   input logic           clk,
   input logic           rst,
   frame_buffer_if.slave bus
);

   localparam logic [1:0] ST_CLEAR   = 2'd0;
   localparam logic [1:0] ST_READY   = 2'd1;
   localparam logic [1:0] ST_LOADING = 2'd2;

   localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

   logic [1:0]  state;
   logic [14:0] clear_ptr;
   logic [14:0] load_ptr;
   logic        load_done_q;
   logic [23:0] proc_rdata_q;
   logic [23:0] disp_data_q;
   logic        disp_valid_q;
   logic        addr_error_q;

   logic        load_ready;
   logic        load_accept;
   logic        proc_grant;
   logic        disp_grant;
   logic [14:0] acc_addr;
   logic        acc_we;
   logic [23:0] acc_wdata;
   logic        acc_in_range;
   logic [23:0] rd_word;

   logic [23:0] mem [DEPTH];

   assign load_ready  = (state == ST_LOADING) && !bus.proc_active;
   assign load_accept = load_ready && bus.load_valid;
   assign proc_grant  = (state != ST_CLEAR) && bus.proc_active;
   assign disp_grant  = (state != ST_CLEAR) && !bus.proc_active && !load_accept && bus.disp_req;

   // One shared array port: the winning client supplies the single address of this cycle.
   always_comb begin
      acc_addr  = clear_ptr;
      acc_we    = 1'b0;
      acc_wdata = CLEAR_VALUE;
      if (state == ST_CLEAR) begin
         acc_we = 1'b1;
      end else if (proc_grant) begin
         acc_addr  = bus.proc_address;
         acc_we    = bus.proc_we && acc_in_range;
         acc_wdata = bus.proc_wdata;
      end else if (load_accept) begin
         acc_addr  = load_ptr;
         acc_we    = 1'b1;
         acc_wdata = bus.load_data;
      end else if (disp_grant) begin
         acc_addr = bus.disp_address;
      end
   end

`ifdef FB_RANGE_CHECK_EN
   assign acc_in_range = (acc_addr <= LAST_ADDR);
`else
   assign acc_in_range = 1'b1;
`endif

   assign rd_word = acc_in_range ? mem[acc_addr] : 24'h000000;

   always_ff @(posedge clk) begin
      if (acc_we) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_CLEAR;
         clear_ptr    <= '0;
         load_ptr     <= '0;
         load_done_q  <= 1'b0;
         proc_rdata_q <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
      end else begin
         load_done_q  <= 1'b0;
         disp_valid_q <= disp_grant;
         if (proc_grant && !bus.proc_we) begin
            proc_rdata_q <= rd_word;
         end
         if (disp_grant) begin
            disp_data_q <= rd_word;
         end
         case (state)
            ST_CLEAR: begin
               if (clear_ptr == LAST_ADDR) begin
                  state     <= ST_READY;
                  clear_ptr <= '0;
               end else begin
                  clear_ptr <= clear_ptr + 15'd1;
               end
            end
            ST_READY: begin
               if (bus.clear_start) begin
                  state     <= ST_CLEAR;
                  clear_ptr <= '0;
               end else if (bus.load_start) begin
                  state    <= ST_LOADING;
                  load_ptr <= '0;
               end
            end
            ST_LOADING: begin
               if (bus.clear_start) begin
                  state     <= ST_CLEAR;
                  clear_ptr <= '0;
               end else if (load_accept) begin
                  if (load_ptr == LAST_ADDR) begin
                     state       <= ST_READY;
                     load_done_q <= 1'b1;
                  end else begin
                     load_ptr <= load_ptr + 15'd1;
                  end
               end
            end
            default: begin
               state     <= ST_CLEAR;
               clear_ptr <= '0;
            end
         endcase
      end
   end

`ifdef FB_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_error_q <= 1'b0;
      end else if (bus.clear_start) begin
         addr_error_q <= 1'b0;
      end else if ((proc_grant || disp_grant) && !acc_in_range) begin
         addr_error_q <= 1'b1;
      end
   end
`else
   assign addr_error_q = 1'b0;
`endif

   assign bus.proc_rdata = proc_rdata_q;
   assign bus.load_ready = load_ready;
   assign bus.load_done  = load_done_q;
   assign bus.disp_data  = disp_data_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.busy       = (state != ST_READY);
   assign bus.addr_error = addr_error_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: randomized traffic against a plain array model of the frame.
module tb_frame_buffer;

   localparam int DEPTH = 19200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frame_buffer_if bus();

   frame_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [23:0] model [DEPTH];
   logic [23:0] exp_prdata;
   logic [23:0] exp_ddata;

   task automatic idle_inputs();
      bus.proc_active  = 1'b0;
      bus.proc_address = '0;
      bus.proc_we      = 1'b0;
      bus.proc_wdata   = '0;
      bus.load_start   = 1'b0;
      bus.load_valid   = 1'b0;
      bus.load_data    = '0;
      bus.disp_req     = 1'b0;
      bus.disp_address = '0;
      bus.clear_start  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic proc_read_check(input int addr, input string name);
      bus.proc_active  = 1'b1;
      bus.proc_we      = 1'b0;
      bus.proc_address = 15'(addr);
      step();
      exp_prdata = model[addr];
      checks++;
      if (bus.proc_rdata !== exp_prdata) begin
         errors++;
         $display("[TB] FAIL %s addr %0d: got %h expected %h", name, addr, bus.proc_rdata, exp_prdata);
      end
      bus.proc_active = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      for (int i = 0; i < DEPTH; i++) model[i] = 24'h000000;
      exp_prdata = '0;
      exp_ddata  = '0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.proc_rdata !== 24'h0) begin errors++; $display("[TB] FAIL reset_proc_rdata: got %h expected 000000", bus.proc_rdata); end
      checks++; if (bus.disp_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_disp_data: got %h expected 000000", bus.disp_data); end
      checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_valid: got %b expected 0", bus.disp_valid); end
      checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_ready: got %b expected 0", bus.load_ready); end
      checks++; if (bus.load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b expected 0", bus.load_done); end
      checks++; if (bus.addr_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_error: got %b expected 0", bus.addr_error); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 1", bus.busy); end
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 25000) begin
         step();
         cnt++;
      end
      checks++;
      if (cnt != DEPTH) begin
         errors++;
         $display("[TB] FAIL clear_cycles: got %0d expected %0d", cnt, DEPTH);
      end
      proc_read_check(0, "cleared_read");
      proc_read_check(9600, "cleared_read");
      proc_read_check(DEPTH - 1, "cleared_read");
   endtask

   task automatic test_load();
      int ptr = 0;
      int cycles = 0;
      int pulses = 0;
      int bad_ready = 0;
      int pa;
      bit win;
      bit v;
      idle_inputs();
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
      while (ptr < DEPTH && cycles < 40000) begin
         win = (cycles >= 3000 && cycles < 3010);
         pa = $urandom_range(0, DEPTH - 1);
         v = ($urandom_range(0, 7) != 0);
         bus.proc_active  = win;
         bus.proc_we      = 1'b0;
         bus.proc_address = 15'(pa);
         bus.disp_req     = win;
         bus.disp_address = 15'(pa);
         bus.load_valid   = v;
         bus.load_data    = 24'(ptr);
         @(negedge clk);
         if (win) begin
            checks++;
            if (bus.load_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL stall_load_ready cycle %0d: got %b expected 0", cycles, bus.load_ready);
            end
         end else if (bus.load_ready !== 1'b1) begin
            bad_ready++;
         end
         step();
         if (win) begin
            exp_prdata = model[pa];
            checks++;
            if (bus.proc_rdata !== exp_prdata) begin
               errors++;
               $display("[TB] FAIL stall_proc_read addr %0d: got %h expected %h", pa, bus.proc_rdata, exp_prdata);
            end
            checks++;
            if (bus.disp_valid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL stall_disp_valid cycle %0d: got %b expected 0", cycles, bus.disp_valid);
            end
         end
         if (v && !win) begin
            model[ptr] = 24'(ptr);
            ptr++;
         end
         if (bus.load_done === 1'b1) pulses++;
         if (ptr == DEPTH) begin
            checks++;
            if (bus.load_done !== 1'b1) begin
               errors++;
               $display("[TB] FAIL load_done_timing: got %b expected 1", bus.load_done);
            end
         end
         cycles++;
      end
      idle_inputs();
      repeat (3) begin
         step();
         if (bus.load_done === 1'b1) pulses++;
      end
      checks++; if (ptr != DEPTH) begin errors++; $display("[TB] FAIL load_beats: got %0d expected %0d", ptr, DEPTH); end
      checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL load_ready_unstalled: got %0d low cycles expected 0", bad_ready); end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL load_done_pulses: got %0d expected 1", pulses); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_load: got %b expected 0", bus.busy); end
   endtask

   task automatic test_display();
      int addrs [6];
      addrs[0] = 121;
      addrs[1] = 0;
      addrs[2] = DEPTH - 1;
      for (int i = 3; i < 6; i++) addrs[i] = $urandom_range(0, DEPTH - 1);
      idle_inputs();
      foreach (addrs[i]) begin
         bus.disp_req     = 1'b1;
         bus.disp_address = 15'(addrs[i]);
         step();
         exp_ddata = model[addrs[i]];
         checks++;
         if (bus.disp_valid !== 1'b1 || bus.disp_data !== exp_ddata) begin
            errors++;
            $display("[TB] FAIL disp_read addr %0d: got valid %b data %h expected valid 1 data %h", addrs[i], bus.disp_valid, bus.disp_data, exp_ddata);
         end
      end
      bus.disp_req = 1'b0;
      step();
      checks++;
      if (bus.disp_valid !== 1'b0 || bus.disp_data !== exp_ddata) begin
         errors++;
         $display("[TB] FAIL disp_idle_hold: got valid %b data %h expected valid 0 data %h", bus.disp_valid, bus.disp_data, exp_ddata);
      end
      checks++;
      if (model[121] !== 24'h000079) begin
         errors++;
         $display("[TB] FAIL loaded_pixel_121: got %h expected 000079", model[121]);
      end
   endtask

   task automatic test_proc_write_read();
      idle_inputs();
      bus.proc_active  = 1'b1;
      bus.proc_we      = 1'b1;
      bus.proc_address = 15'd241;
      bus.proc_wdata   = 24'hABCDEF;
      step();
      model[241] = 24'hABCDEF;
      checks++;
      if (bus.proc_rdata !== exp_prdata) begin
         errors++;
         $display("[TB] FAIL write_holds_rdata: got %h expected %h", bus.proc_rdata, exp_prdata);
      end
      proc_read_check(241, "read_after_write");
   endtask

   task automatic test_random_traffic();
      int pa, da;
      bit act, pw, dr, exp_v;
      logic [23:0] pd;
      idle_inputs();
      for (int n = 0; n < 200; n++) begin
         pa  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(DEPTH - 16, DEPTH - 1);
         da  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(DEPTH - 16, DEPTH - 1);
         act = ($urandom_range(0, 1) == 1);
         pw  = ($urandom_range(0, 1) == 1);
         dr  = ($urandom_range(0, 1) == 1);
         pd  = 24'($urandom);
         bus.proc_active  = act;
         bus.proc_we      = pw;
         bus.proc_address = 15'(pa);
         bus.proc_wdata   = pd;
         bus.disp_req     = dr;
         bus.disp_address = 15'(da);
         exp_v = !act && dr;
         if (act) begin
            if (pw) model[pa] = pd;
            else exp_prdata = model[pa];
         end else if (dr) begin
            exp_ddata = model[da];
         end
         step();
         checks++;
         if (bus.proc_rdata !== exp_prdata) begin
            errors++;
            $display("[TB] FAIL rand_proc_rdata cycle %0d: got %h expected %h", n, bus.proc_rdata, exp_prdata);
         end
         checks++;
         if (bus.disp_valid !== exp_v || bus.disp_data !== exp_ddata) begin
            errors++;
            $display("[TB] FAIL rand_disp cycle %0d: got valid %b data %h expected valid %b data %h", n, bus.disp_valid, bus.disp_data, exp_v, exp_ddata);
         end
      end
      idle_inputs();
   endtask

`ifdef FB_RANGE_CHECK_EN
   task automatic test_range();
      idle_inputs();
      proc_read_check(241, "pre_range_read");
      bus.proc_active  = 1'b1;
      bus.proc_we      = 1'b0;
      bus.proc_address = 15'(DEPTH);
      step();
      exp_prdata = 24'h0;
      checks++; if (bus.proc_rdata !== 24'h0) begin errors++; $display("[TB] FAIL range_read_zero: got %h expected 000000", bus.proc_rdata); end
      checks++; if (bus.addr_error !== 1'b1) begin errors++; $display("[TB] FAIL range_addr_error: got %b expected 1", bus.addr_error); end
      idle_inputs();
      repeat (3) step();
      checks++; if (bus.addr_error !== 1'b1) begin errors++; $display("[TB] FAIL range_sticky: got %b expected 1", bus.addr_error); end
   endtask
`endif

   task automatic test_clear_collision();
      int cnt = 0;
      int bad_ready = 0;
      int pulses = 0;
      idle_inputs();
      bus.load_start  = 1'b1;
      bus.clear_start = 1'b1;
      bus.load_valid  = 1'b1;
      bus.load_data   = 24'h123456;
      step();
      bus.load_start  = 1'b0;
      bus.clear_start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL collision_busy: got %b expected 1", bus.busy); end
`ifdef FB_RANGE_CHECK_EN
      checks++; if (bus.addr_error !== 1'b0) begin errors++; $display("[TB] FAIL clear_resets_addr_error: got %b expected 0", bus.addr_error); end
`endif
      while (bus.busy === 1'b1 && cnt < 25000) begin
         @(negedge clk);
         if (bus.load_ready !== 1'b0) bad_ready++;
         step();
         if (bus.load_done === 1'b1) pulses++;
         cnt++;
      end
      idle_inputs();
      checks++; if (cnt != DEPTH) begin errors++; $display("[TB] FAIL collision_clear_cycles: got %0d expected %0d", cnt, DEPTH); end
      checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL collision_load_ready: got %0d high cycles expected 0", bad_ready); end
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL collision_load_done: got %0d pulses expected 0", pulses); end
      for (int i = 0; i < DEPTH; i++) model[i] = 24'h000000;
      proc_read_check(241, "refill_read");
      proc_read_check(121, "refill_read");
      proc_read_check(DEPTH - 1, "refill_read");
      for (int i = 0; i < 4; i++) proc_read_check($urandom_range(0, DEPTH - 1), "refill_read");
   endtask

   initial begin
      test_reset();
      test_load();
      test_display();
      test_proc_write_read();
      test_random_traffic();
`ifdef FB_RANGE_CHECK_EN
      test_range();
`endif
      test_clear_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Pixel frame store serving the Gaussian-blur image processor, the VGA display scanner and the image loader. It holds one WIDTH×HEIGHT frame of 24-bit RGB pixels in a single-port array and arbitrates one access per cycle. The processor port has fixed 1-cycle read latency and is never stalled. The loader and display ports take the remaining slots. Sits between the processor, display and loader blocks at top level.

## Interface
- WIDTH, 160, frame width in pixels
- HEIGHT, 120, frame height in pixels
- DEPTH, WIDTH*HEIGHT (19200), word count; valid addresses 0..DEPTH-1
- CLEAR_VALUE, 24'h000000, fill value written by clear
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- proc_active  in  1  processor owns the array this cycle
- proc_address  in  15  processor read/write address
- proc_we  in  1  processor write strobe (qualified by proc_active)
- proc_wdata  in  24  processor write pixel
- proc_rdata  out  24  processor read data, 1 cycle after address
- load_start  in  1  pulse: begin sequential load from address 0
- load_valid  in  1  load_data valid
- load_data  in  24  pixel to load
- load_ready  out  1  loader beat accepted when load_valid && load_ready
- load_done  out  1  1-cycle pulse after the last loaded word
- disp_req  in  1  display read request (level)
- disp_address  in  15  display read address
- disp_data  out  24  display read data
- disp_valid  out  1  disp_data updated this cycle
- clear_start  in  1  pulse: refill array with CLEAR_VALUE
- busy  out  1  state is not READY
- addr_error  out  1  sticky out-of-range flag

## Operation
- States: CLEAR, READY, LOADING. Reset enters CLEAR with clear_ptr=0.
- CLEAR:
  - Writes CLEAR_VALUE to mem[clear_ptr] each cycle, then increments clear_ptr.
  - After writing DEPTH-1, moves to READY.
  - All ports are ignored. load_ready=0 and disp_valid=0. proc_rdata holds its value.
- READY:
  - clear_start moves to CLEAR with clear_ptr=0.
  - Otherwise, load_start moves to LOADING with load_ptr=0.
  - If both arrive in the same cycle, clear wins.
- LOADING:
  - load_ready = !proc_active.
  - Each accepted beat writes mem[load_ptr], then increments load_ptr.
  - After the beat at DEPTH-1: load_done pulses, state returns to READY.
  - clear_start aborts the load and moves to CLEAR.
  - load_start is ignored outside READY.
- Arbitration outside CLEAR, one access per cycle, highest priority first:
  1. Processor, when proc_active.
  2. Loader, on an accepted beat.
  3. Display, when disp_req.
- Processor access:
  - proc_we=1: mem[proc_address] <= proc_wdata; proc_rdata holds.
  - proc_we=0: proc_rdata <= mem[proc_address].
  - A read of an address written the previous cycle returns the new data.
- Display access:
  - When granted: disp_data <= mem[disp_address], disp_valid=1 next cycle.
  - When not granted: disp_valid=0 and disp_data holds. The requester retries by keeping disp_req high.
- Out-of-range address (≥DEPTH) on any port:
  - Reads return 24'h0.
  - Writes are dropped.
  - See Configuration for addr_error.
- Address mapping is owned by the clients; this block uses linear word addresses. The loader streams 0..DEPTH-1 in order.

## Timing
- Reset values:
  - proc_rdata=0, disp_data=0, disp_valid=0.
  - load_ready=0, load_done=0, addr_error=0.
  - busy=1 (state CLEAR).
- Clear takes exactly DEPTH cycles. busy falls on the edge after the DEPTH-1 write.
- Read latency is 1 cycle on the processor and display ports.
- Loader throughput is 1 word/cycle while proc_active=0.
- load_done asserts the cycle after the final accepted beat.
- proc_active during CLEAR is ignored and its accesses are lost. The processor must wait for busy=0.
- Reset asserted mid-load or mid-clear aborts immediately. Clear restarts from 0 after reset is released.

## Configuration
- FB_RANGE_CHECK_EN defined:
  - Any port presenting an address ≥DEPTH on a granted access sets addr_error.
  - addr_error stays set until rst or clear_start.
- FB_RANGE_CHECK_EN undefined:
  - No compare logic; addr_error is tied 0.
  - Out-of-range behaviour is unspecified, and clients must not issue such addresses.

## Test plan
- Reset release -> busy=1 for 19200 cycles, then 0. Reading addresses 0, 9600 and 19199 on the processor port returns 24'h000000.
- load_start, then 19200 beats of data=address, with proc_active=0 -> load_ready=1 throughout, load_done pulses once, busy=0. Display reads of address 121 return 24'h000079.
- Processor writes 24'hABCDEF at address 241, then reads 241 the next cycle -> proc_rdata=24'hABCDEF one cycle later.
- During LOADING, proc_active high for 10 cycles with disp_req high -> load_ready=0 and disp_valid=0 for those cycles, and no load beat is lost.
- clear_start in the same cycle as load_start -> state CLEAR, load_ready stays 0, array refilled with CLEAR_VALUE.
- With FB_RANGE_CHECK_EN, a processor read of address 19200 -> proc_rdata=0 and addr_error=1, staying set until clear_start.
